// File: rtl/pc_unit_if.sv
// Control/status bundle between the decoder and the program-counter unit.
// The master (decoder side) drives next-PC controls; the slave (pc_unit) returns fetch address and RAS status.
interface pc_unit_if #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic              stall;
  logic              exc;
  logic              branch;
  logic              equal;
  logic [ADDR_W-1:0] sign_imm;
  logic              jump;
  logic [25:0]       jump_index;
  logic              jr;
  logic [ADDR_W-1:0] jr_target;
  logic              call;
  logic              ret;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc4;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_hit;
  logic              pc_misalign;

  modport master (
    output stall, exc, branch, equal, sign_imm, jump, jump_index,
           jr, jr_target, call, ret,
    input  pc, pc4, ras_count, ras_hit, pc_misalign
  );

  modport slave (
    input  stall, exc, branch, equal, sign_imm, jump, jump_index,
           jr, jr_target, call, ret,
    output pc, pc4, ras_count, ras_hit, pc_misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with branch/jump/register-jump/exception redirect, stall,
// and a circular return-address stack that predicts procedure-return targets.
module pc_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'('h380),
  parameter int                RAS_DEPTH    = 4
) (
  input  logic      clk,
  input  logic      rst,
  pc_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

  // Datapath
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] ret_target;
  logic              ras_nonempty;
  logic              pop_req;
  logic              update;
  logic              unused_sign_msbs;

  assign pc4           = pc_q + ADDR_W'(4);
  assign branch_target = pc4 + {bus.sign_imm[ADDR_W-3:0], 2'b00};
  assign jump_target   = {pc4[ADDR_W-1:28], bus.jump_index, 2'b00};

  // The word offset is shifted left by two, so its top two bits fall off.
  assign unused_sign_msbs = ^bus.sign_imm[ADDR_W-1:ADDR_W-2];

  assign ras_nonempty = (count_q != '0);
  assign ras_top      = ras_q[tp_q];
  assign ret_target   = ras_nonempty ? ras_top : bus.jr_target;
  assign pop_req      = bus.jr & bus.ret & ras_nonempty;
  assign update       = !bus.stall && !bus.exc;

  // Next-PC selection; exception outranks stall so a stalled pipe can still trap.
  always_comb begin
    // NOTE: a default assignment at the top of every always_comb keeps
    // each path fully specified, so no latch can be inferred.
    pc_d = pc4;
    if (bus.exc) begin
      pc_d = EXC_VECTOR;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.jr) begin
      pc_d = bus.ret ? ret_target : bus.jr_target;
    end else if (bus.jump) begin
      pc_d = jump_target;
    end else if (bus.branch && bus.equal) begin
      pc_d = branch_target;
    end
  end

  // Return-address stack: push on call, pop on predicted return, both at once
  // replaces the top in place (jalr through the link register).
  always_comb begin
    ras_d   = ras_q;
    tp_d    = tp_q;
    count_d = count_q;
    if (update) begin
      if (bus.call && pop_req) begin
        ras_d[tp_q] = pc4;
      end else if (bus.call) begin
        ras_d[tp_q + PTR_W'(1)] = pc4;
        tp_d                    = tp_q + PTR_W'(1);
        // When full the oldest slot is the one just overwritten.
        if (count_q != CNT_W'(RAS_DEPTH)) begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (pop_req) begin
        tp_d    = tp_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      tp_q    <= '0;
      count_q <= '0;
      // NOTE: the RAS array is small and must read as zero after reset,
      // so it is reset explicitly rather than left as plain storage.
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      tp_q    <= tp_d;
      count_q <= count_d;
      ras_q   <= ras_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc4         = pc4;
  assign bus.ras_count   = count_q;
  assign bus.ras_hit     = pop_req & update;
  assign bus.pc_misalign = |pc_q[1:0];

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequential fetch, branch/jump, stall/exception
// priority, RAS call/return, overflow, wrap-around and simultaneous push/pop.
module tb_pc_unit;
  localparam int ADDR_W    = 32;
  localparam int RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_unit #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(32'h0),
    .EXC_VECTOR  (32'h0000_0380),
    .RAS_DEPTH   (RAS_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall      = 1'b0;
    bus.exc        = 1'b0;
    bus.branch     = 1'b0;
    bus.equal      = 1'b0;
    bus.sign_imm   = '0;
    bus.jump       = 1'b0;
    bus.jump_index = '0;
    bus.jr         = 1'b0;
    bus.jr_target  = '0;
    bus.call       = 1'b0;
    bus.ret        = 1'b0;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] addr);
    idle();
    bus.jr        = 1'b1;
    bus.jr_target = addr;
    step();
    idle();
  endtask

  task automatic do_ret(input logic [31:0] fallback);
    idle();
    bus.jr        = 1'b1;
    bus.ret       = 1'b1;
    bus.jr_target = fallback;
  endtask

  initial begin
    idle();
    // 1. Reset and sequential fetch
    #12;
    check("rst_pc", bus.pc, 64'h0);
    check("rst_pc4", bus.pc4, 64'h4);
    check("rst_count", bus.ras_count, 64'h0);
    check("rst_hit", bus.ras_hit, 64'h0);
    check("rst_misalign", bus.pc_misalign, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    step(); check("seq_pc4", bus.pc, 64'h4);
    step(); check("seq_pc8", bus.pc, 64'h8);
    step(); check("seq_pc12", bus.pc, 64'hC);
    #2 rst = 1'b0;
    #1 check("async_rst_pc", bus.pc, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // 2. Branch and jump
    set_pc(32'h40);
    check("setpc_40", bus.pc, 64'h40);
    bus.branch = 1'b1; bus.equal = 1'b1; bus.sign_imm = 32'hFFFF_FFFE;
    step(); idle();
    check("branch_back", bus.pc, 64'h3C);
    bus.jump = 1'b1; bus.jump_index = 26'h0000100;
    step(); idle();
    check("jump_400", bus.pc, 64'h400);
    bus.branch = 1'b1; bus.equal = 1'b0;
    step(); idle();
    check("branch_not_taken", bus.pc, 64'h404);

    // 3. Stall and exception priority (jal first so the RAS holds one entry)
    bus.jump = 1'b1; bus.call = 1'b1; bus.jump_index = 26'h200;
    step(); idle();
    check("jal_800", bus.pc, 64'h800);
    check("jal_count", bus.ras_count, 64'h1);
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_index = 26'h300;
    step(); check("stall_hold1", bus.pc, 64'h800);
    step(); check("stall_hold2", bus.pc, 64'h800);
    check("stall_count", bus.ras_count, 64'h1);
    idle();
    bus.stall = 1'b1; bus.exc = 1'b1;
    step(); idle();
    check("exc_over_stall", bus.pc, 64'h380);
    bus.exc = 1'b1; bus.call = 1'b1;
    step(); idle();
    check("exc_call_pc", bus.pc, 64'h380);
    check("exc_call_count", bus.ras_count, 64'h1);
    do_ret(32'h0);
    #1 check("ret_408_hit", bus.ras_hit, 64'h1);
    step(); idle();
    check("ret_408_pc", bus.pc, 64'h408);
    check("ret_408_count", bus.ras_count, 64'h0);

    // 4. RAS call/return
    set_pc(32'h100);
    bus.jump = 1'b1; bus.call = 1'b1; bus.jump_index = 26'h1000;
    step(); idle();
    check("jal_4000", bus.pc, 64'h4000);
    check("jal_4000_count", bus.ras_count, 64'h1);
    do_ret(32'hDEAD_0000);
    #1 check("ret_104_hit", bus.ras_hit, 64'h1);
    step(); idle();
    check("ret_104_pc", bus.pc, 64'h104);
    check("ret_104_count", bus.ras_count, 64'h0);
    do_ret(32'hDEAD_0000);
    #1 check("ret_empty_hit", bus.ras_hit, 64'h0);
    step(); idle();
    check("ret_empty_pc", bus.pc, 64'hDEAD_0000);

    // 5. RAS overflow: the fifth push overwrites the 0x14 entry
    for (int i = 1; i <= 5; i++) begin
      set_pc(32'(i * 16));
      bus.jump = 1'b1; bus.call = 1'b1; bus.jump_index = 26'h40;
      step(); idle();
    end
    check("ovf_count", bus.ras_count, 64'h4);
    do_ret(32'h7770); step(); check("ovf_ret_54", bus.pc, 64'h54);
    do_ret(32'h7770); step(); check("ovf_ret_44", bus.pc, 64'h44);
    do_ret(32'h7770); step(); check("ovf_ret_34", bus.pc, 64'h34);
    do_ret(32'h7770); step(); check("ovf_ret_24", bus.pc, 64'h24);
    check("ovf_drained", bus.ras_count, 64'h0);
    do_ret(32'h7770);
    #1 check("ovf_fifth_hit", bus.ras_hit, 64'h0);
    step(); idle();
    check("ovf_fifth_pc", bus.pc, 64'h7770);

    // 6. Wrap-around and simultaneous push/pop
    set_pc(32'hFFFF_FFFC);
    check("wrap_pc4", bus.pc4, 64'h0);
    step();
    check("wrap_pc", bus.pc, 64'h0);
    set_pc(32'h70);
    bus.jump = 1'b1; bus.call = 1'b1; bus.jump_index = 26'h40;
    step(); idle();
    set_pc(32'h80);
    bus.jump = 1'b1; bus.call = 1'b1; bus.jump_index = 26'h40;
    step(); idle();
    check("pp_count_pre", bus.ras_count, 64'h2);
    set_pc(32'h200);
    do_ret(32'h9999); bus.call = 1'b1;
    #1 check("pp_hit", bus.ras_hit, 64'h1);
    step(); idle();
    check("pp_pc", bus.pc, 64'h84);
    check("pp_count", bus.ras_count, 64'h2);
    do_ret(32'h9999); step(); idle();
    check("pp_ret_204", bus.pc, 64'h204);
    check("pp_ret_count", bus.ras_count, 64'h1);
    do_ret(32'h9999); step(); idle();
    check("pp_ret_74", bus.pc, 64'h74);
    set_pc(32'h102);
    check("misalign_pc", bus.pc, 64'h102);
    check("misalign_flag", bus.pc_misalign, 64'h1);
    do_ret(32'h500); bus.call = 1'b1;
    #1 check("pp_empty_hit", bus.ras_hit, 64'h0);
    step(); idle();
    check("pp_empty_pc", bus.pc, 64'h500);
    check("pp_empty_count", bus.ras_count, 64'h1);
    check("aligned_flag", bus.pc_misalign, 64'h0);
    do_ret(32'h0); step(); idle();
    check("pp_empty_ret", bus.pc, 64'h106);
    bus.jump = 1'b1; bus.jump_index = 26'h3; bus.jr = 1'b1; bus.jr_target = 32'h600;
    step(); idle();
    check("jr_over_jump", bus.pc, 64'h600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the single-cycle core.
- Replaces the fixed 32-bit, branch-only PC register. Adds jump, register-jump, exception redirect, stall, and a small return-address stack (RAS) that predicts `jr $ra` targets.
- Sits between the decode/control logic and instruction memory. Exports `pc` and `pc4` to fetch and to the link-register write path.

Parameters:
- ADDR_W, 32, PC width. Legal range 32..64.
- RESET_VECTOR, 0, value loaded into `pc` on reset.
- EXC_VECTOR, 32'h0000_0380, redirect target on `exc`.
- RAS_DEPTH, 4, number of return-address stack entries. Power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold `pc` and the RAS this cycle
- exc  in  1  exception redirect to EXC_VECTOR
- branch  in  1  current instruction is a conditional branch
- equal  in  1  branch condition true
- sign_imm  in  ADDR_W  sign-extended branch offset, in words
- jump  in  1  j/jal
- jump_index  in  26  instr_index field
- jr  in  1  jr/jalr
- jr_target  in  ADDR_W  register-file value for jr
- call  in  1  jal/jalr: push `pc4` onto the RAS
- ret  in  1  jr $ra: use the RAS top if the stack is non-empty
- pc  out  ADDR_W  current PC (registered)
- pc4  out  ADDR_W  pc + 4 (combinational)
- ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries (registered)
- ras_hit  out  1  ret target taken from the RAS this cycle (combinational)
- pc_misalign  out  1  pc[1:0] != 0 (combinational)

Behaviour:
- **Reset.** On rst low, asynchronously: `pc` = RESET_VECTOR, RAS pointer = 0, `ras_count` = 0, RAS entries = 0. While held, `pc4` = RESET_VECTOR+4, `ras_hit` = 0, and `pc_misalign` follows RESET_VECTOR[1:0]. Reset asserted mid-cycle overrides any pending update.
- **Arithmetic.** All arithmetic is modulo 2^ADDR_W and wraps silently.
  - `pc4` = pc + 4.
  - Branch target = pc4 + (sign_imm << 2), with the top two bits of sign_imm dropped.
  - Jump target = {pc4[ADDR_W-1:28], jump_index, 2'b00}.
  - Ret target = RAS top if `ras_count` > 0, else jr_target.
  - `ras_hit` = jr & ret & (ras_count > 0) & !stall & !exc.
- **Next-PC priority** (highest first), registered at posedge clk:
  1. exc → EXC_VECTOR. Wins even when `stall` = 1.
  2. stall → `pc` held.
  3. jr → ret target if `ret`, else jr_target.
  4. jump → jump target.
  5. branch & equal → branch target.
  6. Otherwise → pc4.
- **Latency.** One cycle from control inputs to the new `pc`. No bubbles are inserted by this block.
- **Control hygiene.** `ret` without `jr` is ignored. `call` without `jump`/`jr` still pushes; the control decoder must not generate it.
- **RAS update.** Only when stall = 0 and exc = 0. Circular buffer, RAS_DEPTH entries, top pointer `tp`.
  - **Push** (`call`): entry[tp+1] = pc4, tp = tp+1.
    - `ras_count` increments, saturating at RAS_DEPTH.
    - Push when full overwrites the oldest entry; `ras_count` stays at RAS_DEPTH.
  - **Pop** (`jr & ret & ras_count > 0`): tp = tp-1, `ras_count` decrements.
    - Pop when empty: no state change; the target falls back to jr_target.
  - **Push and pop in the same cycle** (jalr to $ra): the target is the old top. entry[tp] is overwritten with pc4; tp and `ras_count` are unchanged.
    - If empty: push only, `ras_count` = 1, target = jr_target.
  - `exc` leaves the RAS contents and count untouched.
- **Misalignment.** A misaligned jr_target is loaded unchanged. `pc_misalign` flags it while `pc` holds that value; the exception logic must respond with `exc`.
- **No-ops.** `jump` and `jr` both asserted: jr wins. `branch` with `equal` = 0 → pc4.

Test Plan:
1. **Reset and sequential fetch.** Default params; rst low, then released → pc=0. Three idle cycles → pc=4, 8, 12. Assert rst mid-run → pc=0 immediately, without waiting for a clock edge.
2. **Branch and jump.** At pc=0x40: branch=1, equal=1, sign_imm=-2 → pc=0x3C. At pc=0x3C: jump=1, jump_index=0x0000100 → pc=0x400. At pc=0x400: branch=1, equal=0 → pc=0x404.
3. **Stall and exception priority.**
   - stall=1 with jump=1 for 2 cycles → pc holds, ras_count unchanged.
   - stall=1 and exc=1 → pc=0x380 next cycle.
   - exc=1 with call=1 → ras_count unchanged.
4. **RAS call/return.**
   - jal at pc=0x100 → pc=target, ras_count=1.
   - jr+ret with jr_target=0xDEAD0000 → pc=0x104, ras_hit=1, ras_count=0.
   - jr+ret again → pc=0xDEAD0000, ras_hit=0.
5. **RAS overflow.** Five calls at pcs 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 → ras_count=4. Then four rets return 0x54, 0x44, 0x34, 0x24 and ras_count reaches 0. A fifth ret uses jr_target.
6. **Wrap and simultaneous push/pop.**
   - ADDR_W=32, pc=0xFFFF_FFFC, idle → pc=0.
   - ras_count=2 with top=0x84, then jr+ret+call at pc=0x200 → pc=0x84, ras_count=2, and the next ret returns 0x204.
   - jr_target=0x102 → pc=0x102 with pc_misalign=1.
